// File: rtl/board_gen_stream_if.sv
// rtl/board_gen_stream_if.sv - cell write port from the board generator into the board RAM
interface board_gen_stream_if #(
  parameter int ADDR_W  = 10,
  parameter int COLOR_W = 3
);
  logic               WE;
  logic [ADDR_W-1:0]  WADDR;
  logic [COLOR_W-1:0] WDATA;

  modport master (output WE, WADDR, WDATA);
  modport slave  (input  WE, WADDR, WDATA);
endinterface

// File: rtl/board_gen_stream.sv
// rtl/board_gen_stream.sv - LFSR Flood-It board generator streaming N x N cells to RAM
// Optional feature macro: ADJ_REJECT_EN (reroll a cell equal to its left neighbour)
module board_gen_stream #(
  parameter int          MAX_SIZE     = 26,
  parameter int          SIZE_W       = 5,
  parameter int          COLOR_W      = 3,
  parameter int          ADDR_W       = 10,
  parameter logic [15:0] DEFAULT_SEED = 16'hDAD7
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                NEW_BOARD,
  input  logic [15:0]         seed,
  input  logic [SIZE_W-1:0]   SIZE,
  input  logic [3:0]          COLOR_NUM,
  board_gen_stream_if.master  wr,
  output logic                BUSY,
  output logic                READY
);

  localparam int C_W   = COLOR_W + 1;
  localparam int C_MAX = 1 << COLOR_W;

  typedef enum logic [1:0] {IDLE, STEP, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        r_q, r_d;
  logic [SIZE_W-1:0]  n_q, n_d;
  logic [C_W-1:0]     c_q, c_d;
  logic [SIZE_W-1:0]  row_q, row_d;
  logic [SIZE_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] cand_q, cand_d;

  logic [SIZE_W-1:0]  n_clamp;
  logic [C_W-1:0]     c_clamp;
  logic [15:0]        r_next;
  logic [COLOR_W-1:0] cand;

`ifdef ADJ_REJECT_EN
  logic [COLOR_W-1:0] prev_q, prev_d;
  logic [2:0]         rej_q, rej_d;
  logic [C_W-1:0]     cand_inc;
  logic [COLOR_W-1:0] cand_bump;

  assign cand_inc  = {1'b0, cand} + C_W'(1);
  assign cand_bump = (cand_inc == c_q) ? '0 : cand_inc[COLOR_W-1:0];
`endif

  always_comb begin
    n_clamp = (32'(SIZE) > MAX_SIZE) ? SIZE_W'(MAX_SIZE) : SIZE;
    if (COLOR_NUM < 4'd2)
      c_clamp = C_W'(2);
    else if (32'(COLOR_NUM) > C_MAX)
      c_clamp = C_W'(C_MAX);
    else
      c_clamp = C_W'(COLOR_NUM);
  end

  // The candidate is drawn from the value the LFSR is about to take, not the current one.
  assign r_next = {r_q[14:0], r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10]};
  assign cand   = COLOR_W'(r_next[7:0] % 8'(c_q));

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    n_d     = n_q;
    c_d     = c_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    cand_d  = cand_q;
`ifdef ADJ_REJECT_EN
    prev_d  = prev_q;
    rej_d   = rej_q;
`endif
    case (state_q)
      IDLE: begin
        if (NEW_BOARD) begin
          n_d     = n_clamp;
          c_d     = c_clamp;
          r_d     = (seed == 16'd0) ? DEFAULT_SEED : seed;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
`ifdef ADJ_REJECT_EN
          rej_d   = '0;
`endif
          state_d = (n_clamp == '0) ? DONE : STEP;
        end
      end
      STEP: begin
        r_d     = r_next;
        cand_d  = cand;
        state_d = WRITE;
`ifdef ADJ_REJECT_EN
        if (col_q != '0 && cand == prev_q) begin
          if (rej_q == 3'd7) begin
            cand_d = cand_bump;
          end else begin
            rej_d   = rej_q + 3'd1;
            state_d = STEP;
          end
        end
`endif
      end
      WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
`ifdef ADJ_REJECT_EN
        prev_d = cand_q;
        rej_d  = '0;
`endif
        if (col_q + SIZE_W'(1) == n_q) begin
          col_d   = '0;
          row_d   = row_q + SIZE_W'(1);
          state_d = (row_q + SIZE_W'(1) == n_q) ? DONE : STEP;
        end else begin
          col_d   = col_q + SIZE_W'(1);
          state_d = STEP;
        end
      end
      DONE: begin
        if (!NEW_BOARD) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      r_q     <= DEFAULT_SEED;
      n_q     <= '0;
      c_q     <= C_W'(2);
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      cand_q  <= '0;
`ifdef ADJ_REJECT_EN
      prev_q  <= '0;
      rej_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      n_q     <= n_d;
      c_q     <= c_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      cand_q  <= cand_d;
`ifdef ADJ_REJECT_EN
      prev_q  <= prev_d;
      rej_q   <= rej_d;
`endif
    end
  end

  assign wr.WE    = (state_q == WRITE);
  assign wr.WADDR = addr_q;
  assign wr.WDATA = cand_q;
  assign BUSY     = (state_q == STEP) || (state_q == WRITE);
  assign READY    = (state_q == DONE);

endmodule

// File: tb/tb_board_gen_stream.sv
// tb/tb_board_gen_stream.sv - directed vector bench for board_gen_stream
module tb_board_gen_stream;
  localparam int ADDR_W  = 10;
  localparam int COLOR_W = 3;
  localparam int SIZE_W  = 5;

  logic              CLOCK = 1'b0;
  logic              RESET = 1'b1;
  logic              NEW_BOARD = 1'b0;
  logic [15:0]       seed = 16'd0;
  logic [SIZE_W-1:0] SIZE = '0;
  logic [3:0]        COLOR_NUM = 4'd0;
  logic              BUSY;
  logic              READY;

  board_gen_stream_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) wr ();

  board_gen_stream dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .NEW_BOARD (NEW_BOARD),
    .seed      (seed),
    .SIZE      (SIZE),
    .COLOR_NUM (COLOR_NUM),
    .wr        (wr),
    .BUSY      (BUSY),
    .READY     (READY)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [15:0] seed;
    int          size;
    int          cnum;
    int          exp_n;
    int          exp_c;
    int          exp_first;
    int          hold;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   failures = 0;
  int   first3[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_board(input logic [15:0] s, input int sz, input int cnum,
                           input int exp_n, input int exp_c, input int exp_first,
                           input int hold);
    int          cyc;
    int          cnt;
    int          ready_cyc;
    int          prev;
    int          last;
    int          budget;
    logic [15:0] r;
    r = (s == 16'd0) ? 16'hDAD7 : s;
    budget = 12 * exp_n * exp_n + 20;
    @(negedge CLOCK);
    seed      = s;
    SIZE      = sz[SIZE_W-1:0];
    COLOR_NUM = cnum[3:0];
    NEW_BOARD = 1'b1;
    cyc = 0; cnt = 0; ready_cyc = -1; prev = -1; last = -1;
    while (ready_cyc < 0 && cyc < budget) begin
      @(negedge CLOCK);
      cyc++;
      if (cyc == 1) begin
        seed      = 16'hFFFF;
        SIZE      = SIZE_W'(1);
        COLOR_NUM = 4'd2;
      end
      chk("busy_ready_excl", int'(BUSY & READY), 0);
      if (wr.WE) begin
        chk("waddr", int'(wr.WADDR), cnt);
`ifndef ADJ_REJECT_EN
        r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
        chk("wdata", int'(wr.WDATA), int'(r[7:0]) % exp_c);
        chk("we_cycle", cyc, 2 * cnt + 2);
`else
        chk("wdata_range", int'(int'(wr.WDATA) < exp_c), 1);
        if (exp_n > 0 && (cnt % exp_n) != 0)
          chk("adjacent_differ", int'(int'(wr.WDATA) != prev), 1);
`endif
        if (cnt == 0) chk("first_wdata", int'(wr.WDATA), exp_first);
        if (cnt < 3) first3[cnt] = int'(wr.WDATA);
        prev = int'(wr.WDATA);
        last = int'(wr.WADDR);
        cnt++;
      end
      if (READY) ready_cyc = cyc;
    end
    chk("ready_seen", int'(ready_cyc >= 0), 1);
    chk("write_count", cnt, exp_n * exp_n);
    if (exp_n > 0) chk("last_waddr", last, exp_n * exp_n - 1);
`ifndef ADJ_REJECT_EN
    chk("ready_cycle", ready_cyc, 2 * exp_n * exp_n + 1);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge CLOCK);
      chk("hold_ready", int'(READY), 1);
      chk("hold_no_we", int'(wr.WE), 0);
      chk("hold_busy", int'(BUSY), 0);
    end
    NEW_BOARD = 1'b0;
    @(negedge CLOCK);
    chk("ready_fall", int'(READY), 0);
    chk("idle_busy", int'(BUSY), 0);
  endtask

  initial begin
    int wes;
    int saved[3];

    vecs[0] = '{16'h0000,  2,  4,  2, 4, 2, 50};
    vecs[1] = '{16'h0000,  2,  3,  2, 3, 0,  0};
    vecs[2] = '{16'h0000,  2,  1,  2, 2, 0,  0};
    vecs[3] = '{16'h0000,  3, 15,  3, 8, 6,  0};
    vecs[4] = '{16'h1234,  4,  5,  4, 5, 0,  0};
    vecs[5] = '{16'h0000, 31,  6, 26, 6, 0,  0};
    vecs[6] = '{16'h0000,  0,  4,  0, 4, 0,  0};
    vecs[7] = '{16'h0000,  1,  0,  1, 2, 0,  0};

    RESET = 1'b1;
    repeat (2) @(negedge CLOCK);
    chk("rst_we", int'(wr.WE), 0);
    chk("rst_waddr", int'(wr.WADDR), 0);
    chk("rst_wdata", int'(wr.WDATA), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_ready", int'(READY), 0);
    RESET = 1'b0;

    for (int v = 0; v < 8; v++)
      run_board(vecs[v].seed, vecs[v].size, vecs[v].cnum, vecs[v].exp_n,
                vecs[v].exp_c, vecs[v].exp_first, vecs[v].hold);

    @(negedge CLOCK);
    seed      = 16'h0BAD;
    SIZE      = SIZE_W'(5);
    COLOR_NUM = 4'd5;
    NEW_BOARD = 1'b1;
    wes = 0;
    for (int c = 0; c < 60 && wes < 3; c++) begin
      @(negedge CLOCK);
      if (wr.WE) begin
        saved[wes] = int'(wr.WDATA);
        wes++;
      end
    end
    chk("we_before_reset", wes, 3);
    RESET     = 1'b1;
    NEW_BOARD = 1'b0;
    @(negedge CLOCK);
    chk("midrst_we", int'(wr.WE), 0);
    chk("midrst_waddr", int'(wr.WADDR), 0);
    chk("midrst_wdata", int'(wr.WDATA), 0);
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_ready", int'(READY), 0);
    RESET = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLOCK);
      chk("post_rst_no_we", int'(wr.WE), 0);
      chk("post_rst_busy", int'(BUSY), 0);
    end
    run_board(16'h0BAD, 5, 5, 5, 5, 0, 0);
    for (int i = 0; i < 3; i++) chk("rerun_same", first3[i], saved[i]);

`ifdef ADJ_REJECT_EN
    for (int s = 1; s <= 2; s++)
      for (int c = 2; c <= 8; c++) begin
        logic [15:0] sd;
        logic [15:0] rn;
        sd = 16'(s);
        rn = {sd[14:0], sd[15] ^ sd[13] ^ sd[12] ^ sd[10]};
        run_board(sd, 26, c, 26, c, int'(rn[7:0]) % c, 0);
      end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
